// File: rtl/lifo_stack_ctl.sv
// LIFO stack with registered top-of-stack cache, atomic replace and
// sticky overflow/underflow flags; every operation completes in one clock.
module lifo_stack_ctl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data,
    input  logic              push,
    input  logic              pop,
    input  logic              clear_err,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic [WIDTH-1:0]  top,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_TWO  = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] top_idx;
    logic [ADDR_W-1:0] below_idx;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wr_en;
    logic              set_ovf;
    logic              set_unf;

    assign top_idx   = ADDR_W'(count - CNT_ONE);
    assign below_idx = ADDR_W'(count - CNT_TWO);
    // Replace overwrites the current top slot; a plain push fills the next one.
    assign wr_addr   = pop ? top_idx : count[ADDR_W-1:0];
    assign wr_en     = (push & ~pop & ~full) | (push & pop & ~empty);
    assign set_ovf   = push & ~pop & full;
    assign set_unf   = pop & ~push & empty;

    always_comb begin
        cnt_nxt = count;
        unique case ({push, pop})
            2'b10:   if (!full)  cnt_nxt = count + CNT_ONE;
            2'b01:   if (!empty) cnt_nxt = count - CNT_ONE;
            default: cnt_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en)
            mem[wr_addr] <= data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            top       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= cnt_nxt;
            empty     <= (cnt_nxt == '0);
            full      <= (cnt_nxt == CNT_FULL);
            out_valid <= 1'b0;
            // A new error in the same cycle as clear_err must stay visible.
            overflow  <= (overflow & ~clear_err) | set_ovf;
            underflow <= (underflow & ~clear_err) | set_unf;
            unique case ({push, pop})
                2'b10: begin
                    if (!full)
                        top <= data;
                end
                2'b01: begin
                    if (!empty) begin
                        out       <= top;
                        out_valid <= 1'b1;
                        top       <= (count >= CNT_TWO) ? mem[below_idx] : '0;
                    end
                end
                2'b11: begin
                    out_valid <= 1'b1;
                    if (empty) begin
                        out <= data;
                    end else begin
                        out <= top;
                        top <= data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_stack_ctl.sv
// Scenario bench for lifo_stack_ctl at DEPTH=4; popped words are tracked
// in an expected-output queue filled as each request is driven.
module tb_lifo_stack_ctl;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk;
    logic          reset;
    logic [W-1:0]  data;
    logic          push;
    logic          pop;
    logic          clear_err;
    logic [W-1:0]  out;
    logic          out_valid;
    logic [W-1:0]  top;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    logic [W-1:0]  exp_q [$];
    int            checks;
    int            errors;

    lifo_stack_ctl #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .data(data), .push(push), .pop(pop),
        .clear_err(clear_err), .out(out), .out_valid(out_valid),
        .top(top), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Drive one request for one edge; compare out against the queue afterwards.
    task automatic step(input logic p, input logic q, input logic [W-1:0] d,
                        input logic c, input logic ev, input logic [W-1:0] eo);
        logic [W-1:0] e;
        push = p; pop = q; data = d; clear_err = c;
        if (ev) exp_q.push_back(eo);
        @(posedge clk);
        #1;
        push = 0; pop = 0; clear_err = 0;
        checks++;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_valid_unexpected: got out_valid=1 out=%h, required out_valid=0", out);
            end else begin
                e = exp_q.pop_front();
                if (out !== e) begin
                    errors++;
                    $display("FAIL out_value: got %h, required %h", out, e);
                end
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            errors++;
            $display("FAIL out_valid_missing: got out_valid=%b, required 1 with out=%h", out_valid, e);
        end
    endtask

    task automatic test_reset;
        reset = 1;
        step(0, 0, 16'h0, 0, 0, 16'h0);
        reset = 0;
        checks++;
        if ({count, top, out, empty, full, overflow, underflow} !==
            {3'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got count=%0d top=%h out=%h e=%b f=%b o=%b u=%b, required 0 0 0 1 0 0 0",
                     count, top, out, empty, full, overflow, underflow);
        end
    endtask

    task automatic test_push_pop;
        logic [W-1:0] tops [3];
        tops[0] = 16'h2222; tops[1] = 16'h1111; tops[2] = 16'h0000;
        step(1, 0, 16'h1111, 0, 0, 0);
        step(1, 0, 16'h2222, 0, 0, 0);
        step(1, 0, 16'h3333, 0, 0, 0);
        checks++;
        if (count !== 3'd3 || top !== 16'h3333 || empty !== 1'b0) begin
            errors++;
            $display("FAIL push3: got count=%0d top=%h empty=%b, required 3 3333 0", count, top, empty);
        end
        step(0, 1, 0, 0, 1, 16'h3333);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step(0, 1, 0, 0, 1, (i == 1) ? 16'h2222 : 16'h1111);
            checks++;
            if (top !== tops[i]) begin
                errors++;
                $display("FAIL pop_top%0d: got %h, required %h", i, top, tops[i]);
            end
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (empty !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_empty_end: got empty=%b out_valid=%b, required 1 0", empty, out_valid);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 4; i++) step(1, 0, 16'hA0 + 16'(i), 0, 0, 0);
        checks++;
        if (full !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL fill: got full=%b count=%0d, required 1 4", full, count);
        end
        step(1, 0, 16'hA4, 0, 0, 0);
        checks++;
        if (overflow !== 1'b1 || top !== 16'hA3 || count !== 3'd4) begin
            errors++;
            $display("FAIL overflow: got ovf=%b top=%h count=%0d, required 1 a3 4", overflow, top, count);
        end
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_ovf: got %b, required 0", overflow);
        end
        step(1, 1, 16'h00CC, 0, 1, 16'hA3);
        checks++;
        if (top !== 16'hCC || count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL replace_full: got top=%h count=%0d ovf=%b full=%b, required cc 4 0 1",
                     top, count, overflow, full);
        end
        step(0, 1, 0, 0, 1, 16'hCC);
        checks++;
        if (top !== 16'hA2 || full !== 1'b0) begin
            errors++;
            $display("FAIL pop_after_full: got top=%h full=%b, required a2 0", top, full);
        end
        step(0, 1, 0, 0, 1, 16'hA2);
        step(0, 1, 0, 0, 1, 16'hA1);
        step(0, 1, 0, 0, 1, 16'hA0);
    endtask

    task automatic test_underflow;
        step(0, 1, 0, 0, 0, 0);
        checks++;
        if (underflow !== 1'b1 || out !== 16'hA0 || count !== 3'd0) begin
            errors++;
            $display("FAIL underflow: got unf=%b out=%h count=%0d, required 1 a0 0", underflow, out, count);
        end
        step(0, 1, 0, 1, 0, 0);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_set_wins: got %b, required 1", underflow);
        end
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_unf: got %b, required 0", underflow);
        end
    endtask

    task automatic test_replace;
        step(1, 0, 16'h0005, 0, 0, 0);
        step(1, 1, 16'h0009, 0, 1, 16'h0005);
        checks++;
        if (count !== 3'd1 || top !== 16'h0009) begin
            errors++;
            $display("FAIL replace: got count=%0d top=%h, required 1 0009", count, top);
        end
        step(0, 1, 0, 0, 1, 16'h0009);
        checks++;
        if (empty !== 1'b1 || top !== 16'h0) begin
            errors++;
            $display("FAIL replace_pop: got empty=%b top=%h, required 1 0000", empty, top);
        end
    endtask

    task automatic test_passthrough;
        step(1, 1, 16'hBEEF, 0, 1, 16'hBEEF);
        checks++;
        if (count !== 3'd0 || top !== 16'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL passthrough: got count=%0d top=%h o=%b u=%b, required 0 0000 0 0",
                     count, top, overflow, underflow);
        end
    endtask

    task automatic test_reset_mid;
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 16'h1234, 0, 0, 0);
        step(1, 0, 16'h5678, 0, 0, 0);
        reset = 1;
        step(1, 0, 16'h9999, 0, 0, 0);
        reset = 0;
        checks++;
        if (count !== 3'd0 || top !== 16'h0 || out !== 16'h0 || underflow !== 1'b0 ||
            overflow !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got count=%0d top=%h out=%h u=%b o=%b e=%b, required 0 0 0 0 0 1",
                     count, top, out, underflow, overflow, empty);
        end
        step(1, 0, 16'h7777, 0, 0, 0);
        checks++;
        if (count !== 3'd1 || top !== 16'h7777) begin
            errors++;
            $display("FAIL reset_push: got count=%0d top=%h, required 1 7777", count, top);
        end
        step(0, 1, 0, 0, 1, 16'h7777);
    endtask

    initial begin
        clk = 0; reset = 0; push = 0; pop = 0; clear_err = 0; data = '0;
        checks = 0; errors = 0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_passthrough();
        test_reset_mid();
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
